// File: rtl/dma_utils_pkg.sv
// rtl/dma_utils_pkg.sv - shared AXI4 widths, channel structs, burst/response codes and FSM states
package dma_utils_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  ruser;
    logic                  rvalid;
  } s_axi_miso_t;

  // WRAP needs a power-of-two beat count and a start address aligned to the transfer size
  function automatic logic axi_wrap_ok(input logic [7:0] len, input logic [AXI_ADDR_W-1:0] addr,
                                       input logic [2:0] size);
    logic [AXI_ADDR_W-1:0] w_mask;
    w_mask = (AXI_ADDR_W'(1) << size) - AXI_ADDR_W'(1);
    return ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) &&
           ((addr & w_mask) == '0);
  endfunction
endpackage

// File: rtl/axi_burst_mem_slave_addr_gen.sv
// rtl/axi_burst_mem_slave_addr_gen.sv - combinational next-beat address and burst/range error decode
module axi_burst_addr_gen
  import dma_utils_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
  parameter int                    MEM_BYTES = 4096
) (
  input  logic [AXI_ADDR_W-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [AXI_ADDR_W-1:0] o_next_addr,
  output logic                  o_cfg_err,
  output logic                  o_addr_err
);
  logic [AXI_ADDR_W-1:0] w_step;
  logic [AXI_ADDR_W-1:0] w_incr;
  logic [AXI_ADDR_W-1:0] w_win_mask;
  logic [AXI_ADDR_W-1:0] w_offset;

  always_comb begin
    w_step     = AXI_ADDR_W'(1) << i_size;
    w_incr     = i_addr + w_step;
    w_win_mask = (({24'd0, i_len} + AXI_ADDR_W'(1)) << i_size) - AXI_ADDR_W'(1);
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_WRAP:  o_next_addr = (i_addr & ~w_win_mask) | (w_incr & w_win_mask);
      default:         o_next_addr = w_incr;
    endcase
    o_cfg_err = (i_size > 3'd3) || (i_burst == 2'b11) ||
                ((i_burst == AXI_BURST_WRAP) && !axi_wrap_ok(i_len, i_addr, i_size));
    // Addresses below the base wrap to a huge offset, so one compare covers both ends
    w_offset   = i_addr - MEM_BASE;
    o_addr_err = (w_offset >= AXI_ADDR_W'(MEM_BYTES));
  end
endmodule

// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - AXI4 burst slave with independent read/write engines over a register-array memory
module axi_burst_mem_slave
  import dma_utils_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
  parameter int                    MEM_BYTES = 4096,
  parameter int                    RESP_LAT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);
  localparam int IDX_W = $clog2(MEM_BYTES / 8);

  logic [AXI_DATA_W-1:0] r_mem [MEM_BYTES/8];

  w_state_e              r_wstate, w_wstate_nxt;
  logic [AXI_ADDR_W-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic [AXI_ID_W-1:0]   r_wid;
  logic                  r_wcfg_err, r_wbad;
  logic [3:0]            r_wlat;
  logic                  w_awready, w_wready, w_bvalid, w_aw_hs, w_w_hs;
  logic [AXI_ADDR_W-1:0] w_wag_addr, w_wag_next;
  logic [7:0]            w_wag_len;
  logic [2:0]            w_wag_size;
  logic [1:0]            w_wag_burst;
  logic                  w_wag_cfg_err, w_wag_addr_err, w_wbeat_err;
  logic [IDX_W-1:0]      w_widx;

  r_state_e              r_rstate, w_rstate_nxt;
  logic [AXI_ADDR_W-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic [AXI_ID_W-1:0]   r_rid;
  logic                  r_rcfg_err, r_rlast;
  logic [3:0]            r_rlat;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_arready, w_rvalid, w_ar_hs, w_r_load, w_rbeat_err;
  logic [AXI_ADDR_W-1:0] w_rag_addr, w_rag_next;
  logic [7:0]            w_rag_len, w_r_beat;
  logic [2:0]            w_rag_size;
  logic [1:0]            w_rag_burst;
  logic                  w_rag_cfg_err, w_rag_addr_err;
  logic [IDX_W-1:0]      w_ridx;

  // In IDLE the generators look at the request channel so errors are known at the handshake
  assign w_wag_addr  = (r_wstate == W_IDLE) ? axi_mosi_i.awaddr  : r_waddr;
  assign w_wag_len   = (r_wstate == W_IDLE) ? axi_mosi_i.awlen   : r_wlen;
  assign w_wag_size  = (r_wstate == W_IDLE) ? axi_mosi_i.awsize  : r_wsize;
  assign w_wag_burst = (r_wstate == W_IDLE) ? axi_mosi_i.awburst : r_wburst;
  assign w_rag_addr  = (r_rstate == R_IDLE) ? axi_mosi_i.araddr  : r_raddr;
  assign w_rag_len   = (r_rstate == R_IDLE) ? axi_mosi_i.arlen   : r_rlen;
  assign w_rag_size  = (r_rstate == R_IDLE) ? axi_mosi_i.arsize  : r_rsize;
  assign w_rag_burst = (r_rstate == R_IDLE) ? axi_mosi_i.arburst : r_rburst;

  axi_burst_addr_gen #(.MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES)) u_wr_ag (
    .i_addr(w_wag_addr), .i_len(w_wag_len), .i_size(w_wag_size), .i_burst(w_wag_burst),
    .o_next_addr(w_wag_next), .o_cfg_err(w_wag_cfg_err), .o_addr_err(w_wag_addr_err)
  );

  axi_burst_addr_gen #(.MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES)) u_rd_ag (
    .i_addr(w_rag_addr), .i_len(w_rag_len), .i_size(w_rag_size), .i_burst(w_rag_burst),
    .o_next_addr(w_rag_next), .o_cfg_err(w_rag_cfg_err), .o_addr_err(w_rag_addr_err)
  );

  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        if (axi_mosi_i.awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (axi_mosi_i.wvalid && (r_wcnt == r_wlen))
          w_wstate_nxt = (RESP_LAT == 0) ? W_RESP : W_LAT;
      end
      W_LAT:  if (r_wlat == 4'(RESP_LAT - 1)) w_wstate_nxt = W_RESP;
      W_RESP: begin
        w_bvalid = 1'b1;
        if (axi_mosi_i.bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs     = axi_mosi_i.awvalid && w_awready;
  assign w_w_hs      = axi_mosi_i.wvalid && w_wready;
  assign w_wbeat_err = r_wcfg_err || w_wag_addr_err;
  assign w_widx      = IDX_W'((w_wag_addr - MEM_BASE) >> 3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr <= '0; r_wlen <= '0; r_wsize <= '0; r_wburst <= '0; r_wid <= '0;
      r_wcnt <= '0; r_wcfg_err <= 1'b0; r_wbad <= 1'b0; r_wlat <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr    <= axi_mosi_i.awaddr;
        r_wlen     <= axi_mosi_i.awlen;
        r_wsize    <= axi_mosi_i.awsize;
        r_wburst   <= axi_mosi_i.awburst;
        r_wid      <= axi_mosi_i.awid;
        r_wcnt     <= '0;
        r_wcfg_err <= w_wag_cfg_err;
        r_wbad     <= w_wag_cfg_err;
        r_wlat     <= '0;
      end
      if (w_w_hs) begin
        r_waddr <= w_wag_next;
        r_wcnt  <= r_wcnt + 8'd1;
        // A misplaced or missing wlast poisons the response but the data still lands
        if (w_wbeat_err || (axi_mosi_i.wlast != (r_wcnt == r_wlen))) r_wbad <= 1'b1;
      end
      if (r_wstate == W_LAT) r_wlat <= r_wlat + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_w_hs && !w_wbeat_err) begin
      for (int i = 0; i < AXI_STRB_W; i++)
        if (axi_mosi_i.wstrb[i]) r_mem[w_widx][i*8 +: 8] <= axi_mosi_i.wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (axi_mosi_i.arvalid) w_rstate_nxt = (RESP_LAT == 0) ? R_DATA : R_LAT;
      end
      R_LAT: if (r_rlat == 4'(RESP_LAT - 1)) w_rstate_nxt = R_DATA;
      R_DATA: begin
        w_rvalid = 1'b1;
        if (axi_mosi_i.rready && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs  = axi_mosi_i.arvalid && w_arready;
  // r_raddr always holds the address of the next beat to fetch into r_rdata
  assign w_r_load = ((r_rstate == R_IDLE) && axi_mosi_i.arvalid && (RESP_LAT == 0)) ||
                    ((r_rstate == R_LAT) && (r_rlat == 4'(RESP_LAT - 1))) ||
                    ((r_rstate == R_DATA) && axi_mosi_i.rready && !r_rlast);
  assign w_r_beat    = (r_rstate == R_DATA) ? r_rcnt + 8'd1 : 8'd0;
  assign w_rbeat_err = ((r_rstate == R_IDLE) ? w_rag_cfg_err : r_rcfg_err) || w_rag_addr_err;
  assign w_ridx      = IDX_W'((w_rag_addr - MEM_BASE) >> 3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr <= '0; r_rlen <= '0; r_rsize <= '0; r_rburst <= '0; r_rid <= '0;
      r_rcnt <= '0; r_rcfg_err <= 1'b0; r_rlast <= 1'b0; r_rlat <= '0;
      r_rdata <= '0; r_rresp <= AXI_RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_raddr    <= axi_mosi_i.araddr;
        r_rlen     <= axi_mosi_i.arlen;
        r_rsize    <= axi_mosi_i.arsize;
        r_rburst   <= axi_mosi_i.arburst;
        r_rid      <= axi_mosi_i.arid;
        r_rcnt     <= '0;
        r_rcfg_err <= w_rag_cfg_err;
        r_rlat     <= '0;
      end
      if (r_rstate == R_LAT) r_rlat <= r_rlat + 4'd1;
      if (w_r_load) begin
        r_raddr <= w_rag_next;
        r_rcnt  <= w_r_beat;
        r_rlast <= (w_r_beat == w_rag_len);
        r_rdata <= w_rbeat_err ? '0 : r_mem[w_ridx];
        r_rresp <= w_rbeat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = w_awready;
    axi_miso_o.wready  = w_wready;
    axi_miso_o.bvalid  = w_bvalid;
    axi_miso_o.bid     = r_wid;
    axi_miso_o.bresp   = (w_bvalid && r_wbad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    axi_miso_o.arready = w_arready;
    axi_miso_o.rvalid  = w_rvalid;
    axi_miso_o.rid     = r_rid;
    axi_miso_o.rdata   = r_rdata;
    axi_miso_o.rresp   = r_rresp;
    axi_miso_o.rlast   = r_rlast && w_rvalid;
  end
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - directed self-checking bench for axi_burst_mem_slave
module tb_axi_burst_mem_slave;
  import dma_utils_pkg::*;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi [2];
  s_axi_miso_t miso [2];

  int total = 0;
  int bad   = 0;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          rd_beats, rd_lat, rd_viol, rd_cycles;
  logic        rd_arready_after;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  int          wr_lat, wr_wait;
  logic        wr_awready_after;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(.MEM_BASE(B), .MEM_BYTES(4096), .RESP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi[0]), .axi_miso_o(miso[0])
  );
  axi_burst_mem_slave #(.MEM_BASE(B), .MEM_BYTES(4096), .RESP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi[1]), .axi_miso_o(miso[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int d, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input logic [7:0] strb,
                          input logic [63:0] base, input bit drop_last);
    int n;
    @(negedge clk);
    mosi[d].awid = id; mosi[d].awaddr = addr; mosi[d].awlen = len;
    mosi[d].awsize = 3'd3; mosi[d].awburst = burst; mosi[d].awvalid = 1'b1;
    n = 0;
    while (!miso[d].awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    mosi[d].awvalid = 1'b0;
    wr_wait = -1;
    for (int i = 0; i <= int'(len); i++) begin
      mosi[d].wdata  = base * 64'(i + 1);
      mosi[d].wstrb  = strb;
      mosi[d].wlast  = (i == int'(len)) && !drop_last;
      mosi[d].wvalid = 1'b1;
      n = 0;
      while (!miso[d].wready && n < 50) begin @(negedge clk); n++; end
      if (i == 0) wr_wait = n;
      @(negedge clk);
    end
    mosi[d].wvalid = 1'b0;
    mosi[d].wlast  = 1'b0;
    wr_lat = 0;
    while (!miso[d].bvalid && wr_lat < 50) begin @(negedge clk); wr_lat++; end
    wr_resp = miso[d].bresp;
    wr_bid  = miso[d].bid;
    mosi[d].bready = 1'b1;
    @(negedge clk);
    mosi[d].bready = 1'b0;
    wr_awready_after = miso[d].awready;
  endtask

  task automatic do_read(input int d, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, input bit rnd);
    int n;
    logic [67:0] held;
    bit stalled;
    @(negedge clk);
    mosi[d].arid = id; mosi[d].araddr = addr; mosi[d].arlen = len;
    mosi[d].arsize = 3'd3; mosi[d].arburst = burst; mosi[d].arvalid = 1'b1;
    n = 0;
    while (!miso[d].arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    mosi[d].arvalid = 1'b0;
    rd_lat = 0;
    while (!miso[d].rvalid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
    rd_beats = 0; rd_viol = 0; stalled = 0; n = 0; held = '0; rd_id = 'x;
    while (rd_beats < 16 && n < 300) begin
      if (stalled && ({miso[d].rdata, miso[d].rresp, miso[d].rlast, miso[d].rvalid} !== held))
        rd_viol++;
      mosi[d].rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (miso[d].rvalid && mosi[d].rready) begin
        if (rd_beats == 0) rd_id = miso[d].rid;
        rd_data[rd_beats] = miso[d].rdata;
        rd_resp[rd_beats] = miso[d].rresp;
        rd_last[rd_beats] = miso[d].rlast;
        rd_beats++;
        stalled = 0;
      end else begin
        stalled = miso[d].rvalid;
        held = {miso[d].rdata, miso[d].rresp, miso[d].rlast, miso[d].rvalid};
      end
      @(negedge clk);
      n++;
      if (rd_beats > 0 && rd_last[rd_beats-1]) break;
    end
    rd_cycles = n;
    mosi[d].rready = 1'b0;
    rd_arready_after = miso[d].arready;
  endtask

  initial begin
    mosi[0] = '0;
    mosi[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_flags", {miso[0].awready, miso[0].arready, miso[0].wready, miso[0].bvalid,
                      miso[0].rvalid, miso[0].rlast}, 64'b110000);
    chk("rst_resp_id", {miso[0].bresp, miso[0].rresp, miso[0].bid, miso[0].rid}, 64'h0);
    chk("rst_rdata", miso[0].rdata, 64'h0);

    do_write(0, 4'd5, B + 32'h40, 8'd3, 2'd1, 8'hFF, 64'h11, 1'b0);
    chk("incr_wr_bresp", wr_resp, AXI_RESP_OKAY);
    chk("incr_wr_bid", wr_bid, 64'h5);
    chk("incr_wr_wready_lat", wr_wait, 0);
    chk("incr_wr_bvalid_lat", wr_lat, 0);
    chk("incr_wr_awready_back", wr_awready_after, 1);

    do_read(0, 4'd9, B + 32'h40, 8'd3, 2'd1, 1'b0);
    chk("incr_rd_lat", rd_lat, 0);
    chk("incr_rd_beats", rd_beats, 4);
    chk("incr_rd_cycles", rd_cycles, 4);
    chk("incr_rd_rid", rd_id, 64'h9);
    chk("incr_rd_arready_back", rd_arready_after, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rd_data%0d", i), rd_data[i], 64'h11 * 64'(i + 1));
      chk($sformatf("incr_rd_last%0d", i), rd_last[i], (i == 3));
      chk($sformatf("incr_rd_resp%0d", i), rd_resp[i], AXI_RESP_OKAY);
    end

    do_write(0, 4'd1, B + 32'h20, 8'd3, 2'd1, 8'hFF, 64'h11, 1'b0);
    chk("wrap_prep_bresp", wr_resp, AXI_RESP_OKAY);
    do_read(0, 4'd2, B + 32'h30, 8'd3, 2'd2, 1'b0);
    chk("wrap_rd_beats", rd_beats, 4);
    chk("wrap_rd_d0", rd_data[0], 64'h33);
    chk("wrap_rd_d1", rd_data[1], 64'h44);
    chk("wrap_rd_d2", rd_data[2], 64'h11);
    chk("wrap_rd_d3", rd_data[3], 64'h22);
    chk("wrap_rd_resp3", rd_resp[3], AXI_RESP_OKAY);

    do_read(0, 4'd3, B + 32'h20, 8'd2, 2'd2, 1'b0);
    chk("wrap_bad_beats", rd_beats, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_bad_resp%0d", i), rd_resp[i], AXI_RESP_SLVERR);
      chk($sformatf("wrap_bad_data%0d", i), rd_data[i], 64'h0);
    end
    chk("wrap_bad_last2", rd_last[2], 1);

    do_write(0, 4'd4, B, 8'd0, 2'd1, 8'hFF, 64'hAAAA_5555_AAAA_5555, 1'b0);
    do_write(0, 4'd6, B + 32'd4088, 8'd1, 2'd1, 8'hFF, 64'h11, 1'b0);
    chk("oob_wr_bresp", wr_resp, AXI_RESP_SLVERR);
    do_read(0, 4'd6, B + 32'd4088, 8'd1, 2'd1, 1'b0);
    chk("oob_rd_d0", rd_data[0], 64'h11);
    chk("oob_rd_r0", rd_resp[0], AXI_RESP_OKAY);
    chk("oob_rd_d1", rd_data[1], 64'h0);
    chk("oob_rd_r1", rd_resp[1], AXI_RESP_SLVERR);
    do_read(0, 4'd6, B, 8'd0, 2'd1, 1'b0);
    chk("oob_no_alias", rd_data[0], 64'hAAAA_5555_AAAA_5555);

    do_write(0, 4'd7, B + 32'h80, 8'd0, 2'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    do_write(0, 4'd7, B + 32'h80, 8'd0, 2'd1, 8'h0F, 64'h0, 1'b0);
    do_read(0, 4'd7, B + 32'h80, 8'd0, 2'd1, 1'b0);
    chk("strb_rd", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    do_write(0, 4'd8, B + 32'h180, 8'd1, 2'd1, 8'hFF, 64'h5A, 1'b1);
    chk("nolast_bresp", wr_resp, AXI_RESP_SLVERR);
    do_read(0, 4'd8, B + 32'h180, 8'd1, 2'd1, 1'b0);
    chk("nolast_d0", rd_data[0], 64'h5A);
    chk("nolast_d1", rd_data[1], 64'hB4);

    do_write(1, 4'hA, B + 32'h100, 8'd15, 2'd1, 8'hFF, 64'h0101_0101_0101_0101, 1'b0);
    chk("lat3_wr_bresp", wr_resp, AXI_RESP_OKAY);
    chk("lat3_wr_bvalid_lat", wr_lat, 3);
    do_read(1, 4'hB, B + 32'h100, 8'd15, 2'd1, 1'b1);
    chk("lat3_rd_lat", rd_lat, 3);
    chk("lat3_rd_beats", rd_beats, 16);
    chk("lat3_rd_stable", rd_viol, 0);
    chk("lat3_rd_rid", rd_id, 64'hB);
    for (int i = 0; i < 16; i++)
      chk($sformatf("lat3_rd_data%0d", i), rd_data[i], 64'h0101_0101_0101_0101 * 64'(i + 1));
    chk("lat3_rd_last15", rd_last[15], 1);

    @(negedge clk);
    mosi[0].awaddr = B + 32'h300; mosi[0].awlen = 8'd3; mosi[0].awsize = 3'd3;
    mosi[0].awburst = 2'd1; mosi[0].awvalid = 1'b1;
    mosi[0].araddr = B + 32'h40; mosi[0].arlen = 8'd3; mosi[0].arsize = 3'd3;
    mosi[0].arburst = 2'd1; mosi[0].arvalid = 1'b1;
    @(negedge clk);
    mosi[0].awvalid = 1'b0; mosi[0].arvalid = 1'b0; mosi[0].rready = 1'b0;
    mosi[0].wdata = 64'hDEAD; mosi[0].wstrb = 8'hFF; mosi[0].wlast = 1'b0; mosi[0].wvalid = 1'b1;
    @(negedge clk);
    mosi[0].wvalid = 1'b0;
    chk("pre_rst_busy", {miso[0].awready, miso[0].arready, miso[0].rvalid}, 64'b001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_flags", {miso[0].awready, miso[0].arready, miso[0].bvalid, miso[0].rvalid},
        64'b1100);
    do_write(0, 4'd2, B + 32'h200, 8'd0, 2'd1, 8'hFF, 64'h1234, 1'b0);
    chk("post_rst_bresp", wr_resp, AXI_RESP_OKAY);
    do_read(0, 4'd2, B + 32'h200, 8'd0, 2'd1, 1'b0);
    chk("post_rst_rd", rd_data[0], 64'h1234);
    chk("post_rst_rlast", rd_last[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

AXI4 burst responder backed by an internal register-array memory. It is the slave-side counterpart of the DMA's AXI4 master port and gives the DMA data and descriptor traffic a self-contained target for block and SoC simulation. It sits on `dma_m_mosi`/`dma_m_miso` directly or behind the crossbar. Independent read and write engines each handle one burst at a time and support FIXED, INCR and WRAP bursts.

## Interface
- `MEM_BASE`, `'h0000_0000`: byte address of word 0; requests are decoded relative to it.
- `MEM_BYTES`, `4096`: memory size in bytes; must be a power of two and at least 8.
- `RESP_LAT`, `0`: extra idle cycles inserted before the B response and before the first R beat (0–15).
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `axi_mosi_i`  in  `s_axi_mosi_t`: AXI4 request channels (AW, W, B-ready, AR, R-ready). 64-bit data, widths from `dma_utils_pkg`.
- `axi_miso_o`  out  `s_axi_miso_t`: AXI4 response channels. `buser` and `ruser` are driven to 0.

## Operation
- Write FSM states: `W_IDLE` → `W_DATA` → `W_LAT` → `W_RESP` → `W_IDLE`.
  - `awready = (state == W_IDLE)`.
  - The AW handshake latches id, addr, len, size, burst and computes the error flag.
  - In `W_DATA`, `wready` = 1. Each W handshake writes `wdata` under `wstrb` to word `(addr - MEM_BASE) >> 3`, then advances the address.
  - The beat counter reaching `len` ends `W_DATA`.
  - `W_LAT` is skipped when `RESP_LAT` = 0.
  - `W_RESP` holds `bvalid` with the latched `bid` until `bready`.
- Read FSM states: `R_IDLE` → `R_LAT` → `R_DATA` → `R_IDLE`.
  - `arready = (state == R_IDLE)`.
  - In `R_DATA`, `rdata` is a register loaded from the current address. It is reloaded on each R handshake with the next address, so beats can be back-to-back.
  - `rlast` is asserted on beat `len`.
  - `rid` holds the latched `arid` for the whole burst.
- Address generation, where `step = 1 << size`:
  - FIXED: address unchanged.
  - INCR: `addr + step`.
  - WRAP: `addr + step`, wrapping to the aligned base of a `(len+1)*step` window.
- Errors are latched at address handshake. The response is `SLVERR` (2'b10) on every beat, or on B, if any of the following holds:
  - `size > 3`
  - burst == 2'b11
  - WRAP with `len` not in {1,3,7,15}, or with an unaligned address
  - any beat address outside `[MEM_BASE, MEM_BASE+MEM_BYTES)`, checked per beat
- Error side effects:
  - Erroring write beats are accepted and discarded.
  - Erroring read beats return `rdata` = 0.
- `wlast` asserted on a beat other than beat `len`, or missing on beat `len`, sets `bresp` = SLVERR. The beat counter still governs burst length, and valid data is still written.
- Narrow transfers: data lanes are taken as presented. No lane steering beyond `wstrb`.
- A read and a write to the same word in the same cycle: the read register captures the pre-write value.
- `rst` mid-burst: both FSMs return to IDLE. In-flight bursts are dropped with no B or R response. Memory contents are not reset.

## Timing
- Reset values:
  - `awready` = 1, `arready` = 1.
  - `wready`, `bvalid`, `rvalid`, `rlast` = 0.
  - `bresp`, `rresp`, `bid`, `rid`, `rdata` = 0.
- Write, with `RESP_LAT` = 0:
  - AW handshake at cycle T; `wready` = 1 from T+1.
  - Last W handshake at cycle L; `bvalid` = 1 at L+1.
  - `awready` returns the cycle after the B handshake.
- Read, with `RESP_LAT` = 0:
  - AR handshake at cycle T; first `rvalid` at T+1.
  - One beat per cycle while `rready` = 1.
  - `arready` returns the cycle after the `rlast` handshake.
- `RESP_LAT` = N adds exactly N cycles before `bvalid` and before the first `rvalid`.
- Stability: `rvalid`, `rdata`, `rresp`, `rlast`, `bvalid` and `bresp` are held stable until their handshake.
- `wready` and `rvalid` are never dependent combinationally on `wvalid` or `rready`.
- The read and write engines run fully concurrently.

## Structure
- `dma_utils_pkg` additions:
  - `axi_burst_e` (FIXED=0, INCR=1, WRAP=2)
  - `AXI_RESP_OKAY` = 2'b00, `AXI_RESP_SLVERR` = 2'b10
  - function `axi_wrap_ok(len, addr, size)`
- Sub-module `axi_burst_addr_gen`: combinational next-address logic (addr, len, size, burst → next addr, plus error), instantiated once per engine.
- Memory: `logic [63:0] mem [MEM_BYTES/8]`. One write port with a byte enable per strobe bit, one registered read port.

## Test plan
- INCR write with len=3, size=3 at `MEM_BASE+0x40`, data 0x11..0x44, strobes all ones → `bresp` OKAY at L+1. INCR read of the same burst returns 0x11,0x22,0x33,0x44 back-to-back, `rlast` on beat 4, `rid` equal to `arid`.
- WRAP read with len=3, size=3 at `MEM_BASE+0x30` → beats come from 0x30, 0x38, 0x20, 0x28. WRAP with len=2 → every beat returns SLVERR with `rdata` = 0.
- INCR write starting at `MEM_BASE+MEM_BYTES-8`, len=1 → beat 0 is written, beat 1 is dropped, `bresp` SLVERR. Memory at the first word is updated.
- `wstrb` = 0x0F over a word preloaded with 0xFFFF_FFFF_FFFF_FFFF, `wdata` = 0 → read back 0xFFFF_FFFF_0000_0000.
- `rready` toggled 1/0 randomly during a 16-beat INCR read with `RESP_LAT` = 3 → first `rvalid` 4 cycles after AR. Data stays stable while stalled. No beats are lost or duplicated.
- `rst` pulsed for 1 cycle mid write-burst and mid read-burst → next cycle `awready` = `arready` = 1 and `bvalid` = `rvalid` = 0. A subsequent burst completes normally.
